// File: rtl/clock_pkg.sv
// Shared types and constants for the VGA clock timekeeping path:
// FSM state encoding, field limits and BCD digit widths.
package clock_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RIP_SEC = 2'd1,
    RIP_MIN = 2'd2,
    RIP_HRS = 2'd3
  } state_t;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HRS_MAX = 23;

  localparam int UNITS_W    = 4;
  localparam int TENS_W     = 3;
  localparam int HRS_TENS_W = 2;

  typedef logic [UNITS_W-1:0]    bcd_units_t;
  typedef logic [TENS_W-1:0]     bcd_tens_t;
  typedef logic [HRS_TENS_W-1:0] bcd_hrs_tens_t;

  // Tens digit wraps when it would reach this value (sec/min: 6, hours: 3).
  localparam bcd_tens_t     SEC_TENS_LIM = bcd_tens_t'(SEC_MAX / 10 + 1);
  localparam bcd_tens_t     MIN_TENS_LIM = bcd_tens_t'(MIN_MAX / 10 + 1);
  localparam bcd_hrs_tens_t HRS_TENS_LIM = bcd_hrs_tens_t'(HRS_MAX / 10 + 1);

endpackage

// File: rtl/bcd_field_inc.sv
// Combinational +1 on a two-digit BCD field; the hours instance enables the
// 23->00 wrap, the others wrap when tens reaches the limit.
module bcd_field_inc
  import clock_pkg::*;
#(
  parameter int TENS_W = 3
) (
  input  bcd_units_t        i_units,
  input  logic [TENS_W-1:0] i_tens,
  input  logic [TENS_W-1:0] i_tens_lim,
  input  logic              i_wrap23,
  output bcd_units_t        o_units,
  output logic [TENS_W-1:0] o_tens,
  output logic              o_wrap
);

  always_comb begin
    o_units = i_units + bcd_units_t'(1);
    o_tens  = i_tens;
    o_wrap  = 1'b0;
    if (i_wrap23 && (i_tens == TENS_W'(2)) && (i_units == bcd_units_t'(3))) begin
      o_units = '0;
      o_tens  = '0;
      o_wrap  = 1'b1;
    end else if (i_units == bcd_units_t'(9)) begin
      o_units = '0;
      if (i_tens == (i_tens_lim - TENS_W'(1))) begin
        o_tens = '0;
        o_wrap = 1'b1;
      end else begin
        o_tens = i_tens + TENS_W'(1);
      end
    end
  end

endmodule

// File: rtl/clock_time_ctrl.sv
// Timekeeping controller: 1 s prescaler, sticky request capture, fixed-priority
// arbitration and a one-field-per-cycle carry ripple for HH:MM:SS.
module clock_time_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 31_500_000,
  parameter int DIV_W    = 25
) (
  input  logic       px_clk,
  input  logic       reset,
  input  logic       adj_sec,
  input  logic       adj_min,
  input  logic       adj_hrs,
  output logic [3:0] sec_u,
  output logic [2:0] sec_d,
  output logic [3:0] min_u,
  output logic [2:0] min_d,
  output logic [3:0] hrs_u,
  output logic [1:0] hrs_d,
  output logic [3:0] color_offset,
  output logic       tick,
  output logic       busy
);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] r_divCnt;
  logic             r_tick;
  logic             r_pTick, r_pSec, r_pMin, r_pHrs;
  state_t           r_state;
  logic             r_busy;
  bcd_units_t       r_secU, r_minU, r_hrsU;
  bcd_tens_t        r_secD, r_minD;
  bcd_hrs_tens_t    r_hrsD;
  logic [3:0]       r_color;

  state_t           w_nextState;
  logic             w_accTick, w_accSec, w_accMin, w_accHrs;
  logic             w_incSec, w_incMin, w_incHrs;
  bcd_units_t       w_secUNext, w_minUNext, w_hrsUNext;
  bcd_tens_t        w_secDNext, w_minDNext;
  bcd_hrs_tens_t    w_hrsDNext;
  logic             w_secWrap, w_minWrap, w_hrsWrap;

  bcd_field_inc #(.TENS_W(TENS_W)) u_secInc (
    .i_units(r_secU), .i_tens(r_secD), .i_tens_lim(SEC_TENS_LIM), .i_wrap23(1'b0),
    .o_units(w_secUNext), .o_tens(w_secDNext), .o_wrap(w_secWrap)
  );

  bcd_field_inc #(.TENS_W(TENS_W)) u_minInc (
    .i_units(r_minU), .i_tens(r_minD), .i_tens_lim(MIN_TENS_LIM), .i_wrap23(1'b0),
    .o_units(w_minUNext), .o_tens(w_minDNext), .o_wrap(w_minWrap)
  );

  bcd_field_inc #(.TENS_W(HRS_TENS_W)) u_hrsInc (
    .i_units(r_hrsU), .i_tens(r_hrsD), .i_tens_lim(HRS_TENS_LIM), .i_wrap23(1'b1),
    .o_units(w_hrsUNext), .o_tens(w_hrsDNext), .o_wrap(w_hrsWrap)
  );

  // Free-running prescaler; tick is registered so it lands the cycle after the last count.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_divCnt <= '0;
      r_tick   <= 1'b0;
    end else if (r_divCnt == DIV_LAST) begin
      r_divCnt <= '0;
      r_tick   <= 1'b1;
    end else begin
      r_divCnt <= r_divCnt + DIV_W'(1);
      r_tick   <= 1'b0;
    end
  end

  // Set wins over clear, so a pulse coinciding with acceptance is not lost.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_pTick <= 1'b0;
      r_pSec  <= 1'b0;
      r_pMin  <= 1'b0;
      r_pHrs  <= 1'b0;
    end else begin
      r_pTick <= (r_pTick & ~w_accTick) | r_tick;
      r_pSec  <= (r_pSec  & ~w_accSec)  | adj_sec;
      r_pMin  <= (r_pMin  & ~w_accMin)  | adj_min;
      r_pHrs  <= (r_pHrs  & ~w_accHrs)  | adj_hrs;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accTick   = 1'b0;
    w_accSec    = 1'b0;
    w_accMin    = 1'b0;
    w_accHrs    = 1'b0;
    w_incSec    = 1'b0;
    w_incMin    = 1'b0;
    w_incHrs    = 1'b0;
    case (r_state)
      IDLE: begin
        if (r_pTick) begin
          w_accTick   = 1'b1;
          w_nextState = RIP_SEC;
        end else if (r_pHrs) begin
          w_accHrs = 1'b1;
          w_incHrs = 1'b1;
        end else if (r_pMin) begin
          w_accMin = 1'b1;
          w_incMin = 1'b1;
        end else if (r_pSec) begin
          w_accSec = 1'b1;
          w_incSec = 1'b1;
        end
      end
      RIP_SEC: begin
        w_incSec    = 1'b1;
        w_nextState = w_secWrap ? RIP_MIN : IDLE;
      end
      RIP_MIN: begin
        w_incMin    = 1'b1;
        w_nextState = w_minWrap ? RIP_HRS : IDLE;
      end
      RIP_HRS: begin
        w_incHrs    = 1'b1;
        w_nextState = IDLE;
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_busy  <= (w_nextState != IDLE);
    end
  end

  // Colour offset follows every minutes change, whether from carry or adjust.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      r_secU  <= '0;
      r_secD  <= '0;
      r_minU  <= '0;
      r_minD  <= '0;
      r_hrsU  <= '0;
      r_hrsD  <= '0;
      r_color <= '0;
    end else begin
      if (w_incSec) begin
        r_secU <= w_secUNext;
        r_secD <= w_secDNext;
      end
      if (w_incMin) begin
        r_minU  <= w_minUNext;
        r_minD  <= w_minDNext;
        r_color <= r_color + 4'd1;
      end
      if (w_incHrs) begin
        r_hrsU <= w_hrsWrap ? '0 : w_hrsUNext;
        r_hrsD <= w_hrsWrap ? '0 : w_hrsDNext;
      end
    end
  end

  assign sec_u        = r_secU;
  assign sec_d        = r_secD;
  assign min_u        = r_minU;
  assign min_d        = r_minD;
  assign hrs_u        = r_hrsU;
  assign hrs_d        = r_hrsD;
  assign color_offset = r_color;
  assign tick         = r_tick;
  assign busy         = r_busy;

endmodule

// File: tb/tb_clock_time_ctrl.sv
// Directed bench: a fast-prescaler instance checks tick cadence and second counting,
// a slow instance is preloaded via adjust pulses for carry, priority and merge cases.
module tb_clock_time_ctrl;

  logic px_clk = 1'b0;
  logic reset  = 1'b0;
  logic adjSec = 1'b0, adjMin = 1'b0, adjHrs = 1'b0;
  logic zeroAdj = 1'b0;

  logic [3:0] sSecU, sMinU, sHrsU, sColor;
  logic [2:0] sSecD, sMinD;
  logic [1:0] sHrsD;
  logic       sTick, sBusy;

  logic [3:0] fSecU, fMinU, fHrsU, fColor;
  logic [2:0] fSecD, fMinD;
  logic [1:0] fHrsD;
  logic       fTick, fBusy;

  int nAsserts = 0;
  int nFail    = 0;

  always #5 px_clk = ~px_clk;

  clock_time_ctrl #(.TICK_DIV(1000), .DIV_W(10)) dutSlow (
    .px_clk(px_clk), .reset(reset),
    .adj_sec(adjSec), .adj_min(adjMin), .adj_hrs(adjHrs),
    .sec_u(sSecU), .sec_d(sSecD), .min_u(sMinU), .min_d(sMinD),
    .hrs_u(sHrsU), .hrs_d(sHrsD), .color_offset(sColor),
    .tick(sTick), .busy(sBusy)
  );

  clock_time_ctrl #(.TICK_DIV(4), .DIV_W(3)) dutFast (
    .px_clk(px_clk), .reset(reset),
    .adj_sec(zeroAdj), .adj_min(zeroAdj), .adj_hrs(zeroAdj),
    .sec_u(fSecU), .sec_d(fSecD), .min_u(fMinU), .min_d(fMinD),
    .hrs_u(fHrsU), .hrs_d(fHrsD), .color_offset(fColor),
    .tick(fTick), .busy(fBusy)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    nAsserts++;
    assert (observed === expected)
    else begin
      nFail++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic checkTime(input string tag, input int h, input int m, input int s);
    checkOutput({tag, "_hrs_d"}, 32'(sHrsD), 32'(h / 10));
    checkOutput({tag, "_hrs_u"}, 32'(sHrsU), 32'(h % 10));
    checkOutput({tag, "_min_d"}, 32'(sMinD), 32'(m / 10));
    checkOutput({tag, "_min_u"}, 32'(sMinU), 32'(m % 10));
    checkOutput({tag, "_sec_d"}, 32'(sSecD), 32'(s / 10));
    checkOutput({tag, "_sec_u"}, 32'(sSecU), 32'(s % 10));
  endtask

  task automatic applyReset();
    @(negedge px_clk);
    reset = 1'b1;
    @(negedge px_clk);
    reset = 1'b0;
  endtask

  // kind: 0 = seconds, 1 = minutes, 2 = hours; pulses spaced so each is serviced.
  task automatic applyStimulus(input int kind, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge px_clk);
      adjSec = (kind == 0);
      adjMin = (kind == 1);
      adjHrs = (kind == 2);
      @(negedge px_clk);
      adjSec = 1'b0;
      adjMin = 1'b0;
      adjHrs = 1'b0;
      @(negedge px_clk);
    end
  endtask

  task automatic waitTick(input string tag);
    bit found = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      @(negedge px_clk);
      if (sTick) begin
        found = 1'b1;
        break;
      end
    end
    checkOutput({tag, "_tick_seen"}, 32'(found), 32'd1);
  endtask

  task automatic stepCycles(input int n);
    for (int i = 0; i < n; i++) @(negedge px_clk);
  endtask

  initial begin
    int k;

    // Reset state of both instances.
    applyReset();
    checkTime("rst", 0, 0, 0);
    checkOutput("rst_color", 32'(sColor), 32'd0);
    checkOutput("rst_tick", 32'(sTick), 32'd0);
    checkOutput("rst_busy", 32'(sBusy), 32'd0);
    checkOutput("rst_fast_sec", 32'({fSecD, fSecU}), 32'd0);
    checkOutput("rst_fast_tick", 32'(fTick), 32'd0);

    // Fast instance: a tick every 4 cycles, seconds advance by one per tick.
    k = 0;
    for (int c = 1; c <= 44; c++) begin
      @(negedge px_clk);
      if (fTick) begin
        k++;
        checkOutput("fast_tick_cycle", 32'(c), 32'(4 * k));
        checkOutput("fast_sec_u", 32'(fSecU), 32'((k - 1) % 10));
        checkOutput("fast_sec_d", 32'(fSecD), 32'((k - 1) / 10));
      end
    end
    checkOutput("fast_tick_count", 32'(k), 32'd11);
    checkOutput("fast_min_u", 32'(fMinU), 32'd0);

    // 00:00:59 + tick -> 00:01:00 with two busy cycles.
    applyReset();
    applyStimulus(0, 59);
    checkTime("pre59", 0, 0, 59);
    waitTick("c59");
    stepCycles(1);
    checkOutput("c59_n1_busy", 32'(sBusy), 32'd0);
    stepCycles(1);
    checkOutput("c59_n2_busy", 32'(sBusy), 32'd1);
    checkOutput("c59_n2_sec_u", 32'(sSecU), 32'd9);
    stepCycles(1);
    checkOutput("c59_n3_busy", 32'(sBusy), 32'd1);
    checkTime("c59_n3", 0, 0, 0);
    stepCycles(1);
    checkOutput("c59_n4_busy", 32'(sBusy), 32'd0);
    checkTime("c59_n4", 0, 1, 0);
    checkOutput("c59_color", 32'(sColor), 32'd1);

    // 23:59:59 + tick -> 00:00:00 with three busy cycles.
    applyReset();
    applyStimulus(2, 23);
    applyStimulus(1, 59);
    applyStimulus(0, 59);
    checkTime("pre235959", 23, 59, 59);
    checkOutput("pre235959_color", 32'(sColor), 32'd11);
    waitTick("day");
    stepCycles(2);
    checkOutput("day_n2_busy", 32'(sBusy), 32'd1);
    stepCycles(1);
    checkOutput("day_n3_busy", 32'(sBusy), 32'd1);
    stepCycles(1);
    checkOutput("day_n4_busy", 32'(sBusy), 32'd1);
    checkTime("day_n4", 23, 0, 0);
    stepCycles(1);
    checkOutput("day_n5_busy", 32'(sBusy), 32'd0);
    checkTime("day_n5", 0, 0, 0);
    checkOutput("day_color", 32'(sColor), 32'd12);

    // Adjust wraps carry nothing into the next field.
    applyReset();
    applyStimulus(1, 59);
    applyStimulus(0, 10);
    checkTime("pre5910", 0, 59, 10);
    applyStimulus(1, 1);
    checkTime("adjmin_wrap", 0, 0, 10);
    checkOutput("adjmin_color", 32'(sColor), 32'd12);
    applyStimulus(2, 23);
    checkTime("pre23", 23, 0, 10);
    applyStimulus(2, 1);
    checkTime("adjhrs_wrap", 0, 0, 10);

    // All four requests in the tick cycle: serviced tick, hrs, min, sec.
    applyReset();
    waitTick("prio");
    adjSec = 1'b1;
    adjMin = 1'b1;
    adjHrs = 1'b1;
    @(negedge px_clk);
    adjSec = 1'b0;
    adjMin = 1'b0;
    adjHrs = 1'b0;
    stepCycles(1);
    checkOutput("prio_n2_busy", 32'(sBusy), 32'd1);
    stepCycles(1);
    checkTime("prio_n3", 0, 0, 1);
    stepCycles(1);
    checkTime("prio_n4", 1, 0, 1);
    stepCycles(1);
    checkTime("prio_n5", 1, 1, 1);
    stepCycles(1);
    checkTime("prio_n6", 1, 1, 2);
    stepCycles(3);
    checkTime("prio_final", 1, 1, 2);
    checkOutput("prio_color", 32'(sColor), 32'd1);

    // Second adj_sec while p_sec is still pending is merged.
    applyReset();
    applyStimulus(0, 59);
    waitTick("merge");
    @(negedge px_clk);
    adjSec = 1'b1;
    @(negedge px_clk);
    adjSec = 1'b0;
    @(negedge px_clk);
    checkOutput("merge_ripmin_busy", 32'(sBusy), 32'd1);
    adjSec = 1'b1;
    @(negedge px_clk);
    adjSec = 1'b0;
    stepCycles(4);
    checkTime("merge_final", 0, 1, 1);

    // Reset in RIP_HRS wins over the pending hours update.
    applyReset();
    applyStimulus(2, 22);
    applyStimulus(1, 59);
    applyStimulus(0, 59);
    waitTick("midrst");
    stepCycles(4);
    checkOutput("midrst_ripHrs_busy", 32'(sBusy), 32'd1);
    reset = 1'b1;
    @(negedge px_clk);
    reset = 1'b0;
    checkTime("midrst", 0, 0, 0);
    checkOutput("midrst_color", 32'(sColor), 32'd0);
    checkOutput("midrst_busy", 32'(sBusy), 32'd0);
    stepCycles(3);
    checkTime("midrst_after", 0, 0, 0);
    checkOutput("midrst_after_busy", 32'(sBusy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFail);
    $finish;
  end

endmodule
